// File: rtl/pll_cfg_pkg.sv
// PLL reconfiguration constants and sequencer state encoding shared by the
// mode sequencer and anything that decodes its write stream.
package pll_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_LOCK_BLANK,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_ERROR
    } seq_state_t;

    localparam logic [5:0] ADDR_MODE  = 6'd0;
    localparam logic [5:0] ADDR_N     = 6'd3;
    localparam logic [5:0] ADDR_M     = 6'd4;
    localparam logic [5:0] ADDR_C0    = 6'd5;
    localparam logic [5:0] ADDR_MFRAC = 6'd7;
    localparam logic [5:0] ADDR_START = 6'd2;

    localparam logic [31:0] DATA_MODE  = 32'h0000_0000;
    localparam logic [31:0] DATA_N     = 32'h0001_0000;
    localparam logic [31:0] DATA_M     = 32'h0000_0404;
    localparam logic [31:0] C0_PAL     = 32'h0002_0504;
    localparam logic [31:0] C0_NTSC    = 32'h0000_0505;
    localparam logic [31:0] MFRAC_PAL  = 32'hA3D7_09E8;
    localparam logic [31:0] MFRAC_NTSC = 32'h9745_BF27;
    localparam logic [31:0] DATA_START = 32'h0000_0000;

    localparam logic [2:0] LAST_IDX          = 3'd5;
    localparam int         LOCK_BLANK_CYCLES = 16;

endpackage

// File: rtl/pll_mode_sequencer_if.sv
// PLL reconfiguration management port (write-only, waitrequest-stalled).
interface pll_mode_sequencer_if;
    logic        mgmt_waitrequest;
    logic        mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;

    modport master (input mgmt_waitrequest, output mgmt_write, mgmt_address, mgmt_writedata);
    modport slave  (input mgmt_write, mgmt_address, mgmt_writedata, output mgmt_waitrequest);
endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous level inputs.
module sync_2ff (
    input  logic CLK_50M,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge CLK_50M) begin
        meta <= d;
        q    <= meta;
    end
endmodule

// File: rtl/pll_mode_sequencer.sv
// Reprograms the video PLL for PAL/NTSC on a mode change, waits for lock and
// a settle period, and holds the emulation core in reset until the clock is good.
module pll_mode_sequencer
    import pll_cfg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int MAX_RETRY     = 3
) (
    input  logic                 CLK_50M,
    input  logic                 RESET,
    input  logic                 pal,
    input  logic                 pll_locked,
    pll_mode_sequencer_if.master mgmt,
    output logic                 core_reset,
    output logic                 busy,
    output logic                 error
);
    localparam int CNT_MAX = (LOCK_TIMEOUT > SETTLE_CYCLES) ?
                             ((LOCK_TIMEOUT > LOCK_BLANK_CYCLES) ? LOCK_TIMEOUT : LOCK_BLANK_CYCLES) :
                             ((SETTLE_CYCLES > LOCK_BLANK_CYCLES) ? SETTLE_CYCLES : LOCK_BLANK_CYCLES);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [CW-1:0] BLANK_TC   = CW'(LOCK_BLANK_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_TC = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SETTLE_TC  = CW'(SETTLE_CYCLES - 1);

    logic pal_s, lock_s;

    sync_2ff u_sync_pal  (.CLK_50M(CLK_50M), .d(pal),        .q(pal_s));
    sync_2ff u_sync_lock (.CLK_50M(CLK_50M), .d(pll_locked), .q(lock_s));

    seq_state_t    state_q, state_n;
    logic [2:0]    idx_q, idx_n;
    logic [CW-1:0] cnt_q, cnt_n, cnt_inc;
    logic [RW-1:0] retry_q, retry_n;
    logic          target_q, target_n, applied_q, applied_n;
    logic          mw_q, mw_n, core_reset_q, core_reset_n, busy_q, busy_n, error_q, error_n;
    logic [5:0]    addr_q, addr_n, tbl_addr;
    logic [31:0]   data_q, data_n, tbl_data;

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // Mode-dependent entries always use the latched target, never live pal_s.
    always_comb begin
        tbl_addr = ADDR_MODE;
        tbl_data = DATA_MODE;
        case (idx_q)
            3'd0:    begin tbl_addr = ADDR_MODE;  tbl_data = DATA_MODE;  end
            3'd1:    begin tbl_addr = ADDR_N;     tbl_data = DATA_N;     end
            3'd2:    begin tbl_addr = ADDR_M;     tbl_data = DATA_M;     end
            3'd3:    begin tbl_addr = ADDR_C0;    tbl_data = target_q ? C0_PAL : C0_NTSC;       end
            3'd4:    begin tbl_addr = ADDR_MFRAC; tbl_data = target_q ? MFRAC_PAL : MFRAC_NTSC; end
            3'd5:    begin tbl_addr = ADDR_START; tbl_data = DATA_START; end
            default: begin tbl_addr = ADDR_MODE;  tbl_data = DATA_MODE;  end
        endcase
    end

    always_comb begin
        state_n      = state_q;
        idx_n        = idx_q;
        cnt_n        = cnt_q;
        retry_n      = retry_q;
        target_n     = target_q;
        applied_n    = applied_q;
        mw_n         = 1'b0;
        addr_n       = addr_q;
        data_n       = data_q;
        core_reset_n = core_reset_q;
        busy_n       = busy_q;
        error_n      = error_q;
        case (state_q)
            ST_IDLE: begin
                if (pal_s != applied_q) begin
                    target_n     = pal_s;
                    retry_n      = '0;
                    idx_n        = '0;
                    core_reset_n = 1'b1;
                    busy_n       = 1'b1;
                    state_n      = ST_WRITE;
                end
            end
            ST_WRITE: begin
                core_reset_n = 1'b1;
                busy_n       = 1'b1;
                // Issue takes one cycle, then hold until the slave accepts.
                if (!mw_q) begin
                    mw_n   = 1'b1;
                    addr_n = tbl_addr;
                    data_n = tbl_data;
                end else if (mgmt.mgmt_waitrequest) begin
                    mw_n = 1'b1;
                end else if (idx_q == LAST_IDX) begin
                    cnt_n   = '0;
                    state_n = ST_LOCK_BLANK;
                end else begin
                    idx_n = idx_q + 3'd1;
                end
            end
            ST_LOCK_BLANK: begin
                if (cnt_q == BLANK_TC) begin
                    cnt_n   = '0;
                    state_n = ST_WAIT_LOCK;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    cnt_n   = '0;
                    state_n = ST_SETTLE;
                end else if (cnt_q == TIMEOUT_TC) begin
                    cnt_n   = '0;
                    retry_n = (&retry_q) ? retry_q : retry_q + 1'b1;
                    if (int'(retry_q) + 1 >= MAX_RETRY) begin
                        error_n = 1'b1;
                        busy_n  = 1'b0;
                        state_n = ST_ERROR;
                    end else begin
                        idx_n   = '0;
                        state_n = ST_WRITE;
                    end
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ST_SETTLE: begin
                if (!lock_s) begin
                    cnt_n = '0;
                end else if (cnt_q == SETTLE_TC) begin
                    applied_n    = target_q;
                    core_reset_n = 1'b0;
                    busy_n       = 1'b0;
                    state_n      = ST_IDLE;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ST_ERROR: begin
                core_reset_n = 1'b1;
                error_n      = 1'b1;
                if (pal_s != target_q) begin
                    target_n = pal_s;
                    retry_n  = '0;
                    idx_n    = '0;
                    error_n  = 1'b0;
                    busy_n   = 1'b1;
                    state_n  = ST_WRITE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            state_q      <= ST_WRITE;
            idx_q        <= '0;
            cnt_q        <= '0;
            retry_q      <= '0;
            target_q     <= pal_s;
            applied_q    <= 1'b0;
            mw_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b1;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_n;
            idx_q        <= idx_n;
            cnt_q        <= cnt_n;
            retry_q      <= retry_n;
            target_q     <= target_n;
            applied_q    <= applied_n;
            mw_q         <= mw_n;
            addr_q       <= addr_n;
            data_q       <= data_n;
            core_reset_q <= core_reset_n;
            busy_q       <= busy_n;
            error_q      <= error_n;
        end
    end

    assign mgmt.mgmt_write     = mw_q;
    assign mgmt.mgmt_address   = addr_q;
    assign mgmt.mgmt_writedata = data_q;
    assign core_reset          = core_reset_q;
    assign busy                = busy_q;
    assign error               = error_q;

endmodule
